codigo_serializador: RTL

//  Transmit side of the 6-bit line code: maps a 5-bit symbol index (0..21) to its
//  6-bit codeword and shifts it out serially, MSB first, BIT_CICLOS clocks per bit,

---
 rtl/codigo_serializador_pkg.sv | 38 +++
 rtl/codigo_serializador_if.sv | 31 +++
 rtl/codigo_serializador_tabla.sv | 26 ++
 rtl/codigo_serializador.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/codigo_serializador_pkg.sv
`default_nettype none
// ============================================================================
// Module : codigo_pkg
// Brief  : Shared definitions for the 6-bit line code (code table, widths,
//          serializer state encoding). Used by the serializer and by any
//          future decoder/checker so both ends agree on the code set.
// Rev    : 1.0  initial release
// ============================================================================
package codigo_pkg;

  localparam int NUM_SIMBOLOS  = 22;
  localparam int CODIGO_ANCHO  = 6;
  localparam int SIMBOLO_ANCHO = 5;

  typedef logic [CODIGO_ANCHO-1:0]  codigo_t;
  typedef logic [SIMBOLO_ANCHO-1:0] simbolo_t;

  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    TRANSMITE = 2'd1,
    GUARDA    = 2'd2
  } estado_t;

  // Index -> codeword. Every codeword is non-zero so an idle line never
  // aliases to a legal word on the far end.
  localparam codigo_t TABLA_CODIGOS [NUM_SIMBOLOS] = '{
    6'd1,  6'd2,  6'd3,  6'd5,  6'd10, 6'd12, 6'd13, 6'd15,
    6'd20, 6'd21, 6'd22, 6'd23, 6'd25, 6'd30, 6'd31, 6'd32,
    6'd33, 6'd35, 6'd50, 6'd51, 6'd52, 6'd53
  };

  // True when the index addresses an entry of the code table.
  function automatic logic simbolo_valido(input simbolo_t s);
    return (s < SIMBOLO_ANCHO'(NUM_SIMBOLOS));
  endfunction

endpackage : codigo_pkg
`default_nettype wire

// File: rtl/codigo_serializador_if.sv
`default_nettype none
// ============================================================================
// Module : codigo_serializador_if
// Brief  : Symbol handshake plus serial line outputs of the code serializer.
//          master = symbol source / line monitor, slave = serializer.
// Rev    : 1.0  initial release
// ============================================================================
interface codigo_serializador_if;
  import codigo_pkg::*;

  simbolo_t    Simbolo;
  logic        SimboloValido;
  logic        Listo;
  logic        Salida;
  logic        SalidaValida;
  logic        Inicio;
  logic        Error;
  logic [7:0]  ContErrores;

  modport master (
    output Simbolo, SimboloValido,
    input  Listo, Salida, SalidaValida, Inicio, Error, ContErrores
  );

  modport slave (
    input  Simbolo, SimboloValido,
    output Listo, Salida, SalidaValida, Inicio, Error, ContErrores
  );

endinterface : codigo_serializador_if
`default_nettype wire

// File: rtl/codigo_serializador_tabla.sv
`default_nettype none
// ============================================================================
// Module : codigo_tabla
// Brief  : Combinational symbol index -> 6-bit codeword lookup with a valid
//          flag. Out-of-range indices return codeword 0 and valido_o = 0.
// Rev    : 1.0  initial release
// ============================================================================
module codigo_tabla
  import codigo_pkg::*;
(
  input  simbolo_t indice_i,
  output codigo_t  codigo_o,
  output logic     valido_o
);

  // Range check first so the table is never addressed past its last entry.
  always_comb begin
    valido_o = simbolo_valido(indice_i);
    codigo_o = '0;
    if (valido_o) begin
      codigo_o = TABLA_CODIGOS[indice_i];
    end
  end

endmodule : codigo_tabla
`default_nettype wire

// File: rtl/codigo_serializador.sv
`default_nettype none
// ============================================================================
// Module : codigo_serializador
// Brief  : Transmit side of the 6-bit line code. Accepts a symbol index,
//          looks up its codeword and shifts it out MSB first, BIT_CICLOS
//          clocks per bit, followed by GUARDA_BITS idle bit-times.
//          Out-of-range symbols are dropped with an Error pulse and counted.
// Rev    : 1.0  initial release
// ============================================================================
module codigo_serializador
  import codigo_pkg::*;
#(
  parameter int BIT_CICLOS  = 4,
  parameter int GUARDA_BITS = 1
) (
  input  wire logic           Reloj,
  input  wire logic           Reset_n,
  codigo_serializador_if.slave bus
);

  // A counter of width 0 is not representable, so one bit is the floor.
  localparam int c_ciclo_ancho  = (BIT_CICLOS  > 1) ? $clog2(BIT_CICLOS)  : 1;
  localparam int c_guarda_ancho = (GUARDA_BITS > 1) ? $clog2(GUARDA_BITS) : 1;
  localparam logic [c_ciclo_ancho-1:0]  c_ciclo_max  = c_ciclo_ancho'(BIT_CICLOS - 1);
  localparam logic [c_guarda_ancho-1:0] c_guarda_max =
    c_guarda_ancho'((GUARDA_BITS > 0) ? GUARDA_BITS - 1 : 0);
  localparam logic [2:0] c_ultimo_bit = 3'(CODIGO_ANCHO - 1);
  localparam logic       c_hay_guarda = (GUARDA_BITS > 0);

  estado_t                    estado_q;
  logic                       listo_q;
  logic                       salida_q;
  logic                       salida_valida_q;
  logic                       inicio_q;
  logic                       error_q;
  logic [7:0]                 cont_errores_q;
  logic [7:0]                 cont_errores_d;
  codigo_t                    desplaza_q;
  logic [c_ciclo_ancho-1:0]   ciclo_q;
  logic [2:0]                 bit_q;
  logic [c_guarda_ancho-1:0]  guarda_q;

  codigo_t w_codigo;
  logic    w_valido;
  logic    w_transferencia;

  codigo_tabla u_tabla (
    .indice_i (bus.Simbolo),
    .codigo_o (w_codigo),
    .valido_o (w_valido)
  );

  assign w_transferencia = bus.SimboloValido & listo_q;

  // Saturating next value of the dropped-symbol counter.
  always_comb begin
    cont_errores_d = cont_errores_q;
    if (cont_errores_q != 8'hFF) begin
      cont_errores_d = cont_errores_q + 8'd1;
    end
  end

  // Serializer FSM: owns state, shift register, counters and every output.
  always_ff @(posedge Reloj or negedge Reset_n) begin
    if (!Reset_n) begin
      estado_q        <= REPOSO;
      listo_q         <= 1'b1;
      salida_q        <= 1'b0;
      salida_valida_q <= 1'b0;
      inicio_q        <= 1'b0;
      error_q         <= 1'b0;
      cont_errores_q  <= 8'd0;
      desplaza_q      <= '0;
      ciclo_q         <= '0;
      bit_q           <= '0;
      guarda_q        <= '0;
    end else begin
      inicio_q <= 1'b0;
      error_q  <= 1'b0;
      unique case (estado_q)
        REPOSO: begin
          ciclo_q  <= '0;
          bit_q    <= '0;
          guarda_q <= '0;
          if (w_transferencia) begin
            if (w_valido) begin
              // First bit goes on the line the cycle after the transfer.
              estado_q        <= TRANSMITE;
              listo_q         <= 1'b0;
              desplaza_q      <= w_codigo;
              salida_q        <= w_codigo[CODIGO_ANCHO-1];
              salida_valida_q <= 1'b1;
              inicio_q        <= 1'b1;
            end else begin
              error_q        <= 1'b1;
              cont_errores_q <= cont_errores_d;
            end
          end
        end

        TRANSMITE: begin
          if (ciclo_q == c_ciclo_max) begin
            ciclo_q <= '0;
            if (bit_q == c_ultimo_bit) begin
              bit_q           <= '0;
              salida_q        <= 1'b0;
              salida_valida_q <= 1'b0;
              if (c_hay_guarda) begin
                estado_q <= GUARDA;
              end else begin
                estado_q <= REPOSO;
                listo_q  <= 1'b1;
              end
            end else begin
              bit_q      <= bit_q + 3'd1;
              salida_q   <= desplaza_q[CODIGO_ANCHO-2];
              desplaza_q <= {desplaza_q[CODIGO_ANCHO-2:0], 1'b0};
            end
          end else begin
            ciclo_q <= ciclo_q + 1'b1;
          end
        end

        GUARDA: begin
          if (ciclo_q == c_ciclo_max) begin
            ciclo_q <= '0;
            if (guarda_q == c_guarda_max) begin
              guarda_q <= '0;
              estado_q <= REPOSO;
              listo_q  <= 1'b1;
            end else begin
              guarda_q <= guarda_q + 1'b1;
            end
          end else begin
            ciclo_q <= ciclo_q + 1'b1;
          end
        end

        default: begin
          estado_q        <= REPOSO;
          listo_q         <= 1'b1;
          salida_q        <= 1'b0;
          salida_valida_q <= 1'b0;
          ciclo_q         <= '0;
          bit_q           <= '0;
          guarda_q        <= '0;
        end
      endcase
    end
  end

  assign bus.Listo        = listo_q;
  assign bus.Salida       = salida_q;
  assign bus.SalidaValida = salida_valida_q;
  assign bus.Inicio       = inicio_q;
  assign bus.Error        = error_q;
  assign bus.ContErrores  = cont_errores_q;

endmodule : codigo_serializador
`default_nettype wire
